// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit
// Purpose  : X/M-stage operand forwarding, decode write-through bypass, and
//            load-use / mult-div stall control for a 5-stage pipeline.
// Options  : HAZ_STATS_EN adds saturating forward/stall event counters.
// Revision : 1.0
// ============================================================================
module hazard_fwd_unit #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] fd_rs1,
  input  logic [REG_AW-1:0] fd_rs2,
  input  logic [REG_AW-1:0] fd_rd,
  input  logic              fd_we,
  input  logic              fd_is_md,
  input  logic [REG_AW-1:0] dx_rs1,
  input  logic [REG_AW-1:0] dx_rs2,
  input  logic [REG_AW-1:0] dx_rd,
  input  logic              dx_we,
  input  logic              dx_is_load,
  input  logic              dx_is_md,
  input  logic [REG_AW-1:0] xm_rd,
  input  logic              xm_we,
  input  logic              xm_is_store,
  input  logic [REG_AW-1:0] xm_rs2,
  input  logic [REG_AW-1:0] mw_rd,
  input  logic              mw_we,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_st,
  output logic              fd_byp1,
  output logic              fd_byp2,
  output logic              stall_fd,
  output logic              bubble_dx,
  output logic              md_busy,
  output logic              md_done,
  output logic [REG_AW-1:0] md_rd
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]       stat_fwd,
  output logic [15:0]       stat_ldstall,
  output logic [15:0]       stat_mdstall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  localparam logic [CNT_W-1:0] c_cntLoad = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] c_cntLast = CNT_W'(1);

  mdState_t          r_state;
  logic [CNT_W-1:0]  r_mdCnt;
  logic [REG_AW-1:0] r_mdRd;
  logic              r_mdBusy;
  logic              r_mdDone;

  logic              w_xmValid;
  logic              w_mwValid;
  logic [1:0]        w_fwdA;
  logic [1:0]        w_fwdB;
  logic              w_fwdSt;
  logic              w_byp1;
  logic              w_byp2;
  logic              w_ldUse;
  logic              w_mdStall;

  assign w_xmValid = xm_we && (xm_rd != '0);
  assign w_mwValid = mw_we && (mw_rd != '0);

  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (w_xmValid && (xm_rd == dx_rs1))      w_fwdA = 2'b01;
    else if (w_mwValid && (mw_rd == dx_rs1)) w_fwdA = 2'b10;
    if (w_xmValid && (xm_rd == dx_rs2))      w_fwdB = 2'b01;
    else if (w_mwValid && (mw_rd == dx_rs2)) w_fwdB = 2'b10;
  end

  assign w_fwdSt = xm_is_store && w_mwValid && (mw_rd == xm_rs2);
  assign w_byp1  = w_mwValid && (mw_rd == fd_rs1);
  assign w_byp2  = w_mwValid && (mw_rd == fd_rs2);

  assign w_ldUse = dx_is_load && dx_we && (dx_rd != '0) &&
                   ((dx_rd == fd_rs1) || (dx_rd == fd_rs2));

  // RAW, WAW and structural conflicts with the in-flight mult/div
  assign w_mdStall = r_mdBusy &&
                     (((r_mdRd != '0) && ((fd_rs1 == r_mdRd) || (fd_rs2 == r_mdRd))) ||
                      (fd_we && (fd_rd == r_mdRd)) ||
                      fd_is_md);

  // Combinational selects are forced low while reset is held
  assign fwd_a     = reset ? 2'b00 : w_fwdA;
  assign fwd_b     = reset ? 2'b00 : w_fwdB;
  assign fwd_st    = !reset && w_fwdSt;
  assign fd_byp1   = !reset && w_byp1;
  assign fd_byp2   = !reset && w_byp2;
  assign stall_fd  = !reset && (w_ldUse || w_mdStall);
  assign bubble_dx = stall_fd;
  assign md_busy   = r_mdBusy;
  assign md_done   = r_mdDone;
  assign md_rd     = r_mdRd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mdCnt  <= '0;
      r_mdRd   <= '0;
      r_mdBusy <= 1'b0;
      r_mdDone <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dx_is_md) begin
            r_state  <= BUSY;
            r_mdCnt  <= c_cntLoad;
            r_mdRd   <= dx_rd;
            r_mdBusy <= 1'b1;
            r_mdDone <= (c_cntLoad == '0);
          end
        end
        BUSY: begin
          r_mdCnt <= r_mdCnt - 1'b1;
          if (r_mdCnt == c_cntLast) begin
            r_state  <= DONE;
            r_mdDone <= 1'b1;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_mdCnt  <= '0;
          r_mdRd   <= '0;
          r_mdBusy <= 1'b0;
          r_mdDone <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_mdCnt  <= '0;
          r_mdRd   <= '0;
          r_mdBusy <= 1'b0;
          r_mdDone <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZ_STATS_EN
  logic [15:0] r_statFwd;
  logic [15:0] r_statLd;
  logic [15:0] r_statMd;
  logic        w_anyFwd;

  assign w_anyFwd = (w_fwdA != 2'b00) || (w_fwdB != 2'b00) || w_fwdSt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_statFwd <= '0;
      r_statLd  <= '0;
      r_statMd  <= '0;
    end else begin
      if (w_anyFwd && (r_statFwd != 16'hFFFF))  r_statFwd <= r_statFwd + 16'd1;
      if (w_ldUse && (r_statLd != 16'hFFFF))    r_statLd  <= r_statLd + 16'd1;
      if (w_mdStall && (r_statMd != 16'hFFFF))  r_statMd  <= r_statMd + 16'd1;
    end
  end

  assign stat_fwd     = r_statFwd;
  assign stat_ldstall = r_statLd;
  assign stat_mdstall = r_statMd;
`else
  // Event counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_unit
// Purpose  : Directed scoreboard bench for hazard_fwd_unit (MD_LAT = 4).
// Revision : 1.0
// ============================================================================
module tb_hazard_fwd_unit;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] fd_rs1, fd_rs2, fd_rd, dx_rs1, dx_rs2, dx_rd, xm_rd, xm_rs2, mw_rd;
  logic          fd_we, fd_is_md, dx_we, dx_is_load, dx_is_md, xm_we, xm_is_store, mw_we;
  logic [1:0]    fwd_a, fwd_b;
  logic          fwd_st, fd_byp1, fd_byp2, stall_fd, bubble_dx, md_busy, md_done;
  logic [AW-1:0] md_rd;
`ifdef HAZ_STATS_EN
  logic [15:0]   stat_fwd, stat_ldstall, stat_mdstall;
`endif

  always #5 clock = ~clock;

  hazard_fwd_unit #(.REG_AW(AW), .MD_LAT(LAT), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_rd(fd_rd), .fd_we(fd_we), .fd_is_md(fd_is_md),
    .dx_rs1(dx_rs1), .dx_rs2(dx_rs2), .dx_rd(dx_rd), .dx_we(dx_we),
    .dx_is_load(dx_is_load), .dx_is_md(dx_is_md),
    .xm_rd(xm_rd), .xm_we(xm_we), .xm_is_store(xm_is_store), .xm_rs2(xm_rs2),
    .mw_rd(mw_rd), .mw_we(mw_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_st(fwd_st), .fd_byp1(fd_byp1), .fd_byp2(fd_byp2),
    .stall_fd(stall_fd), .bubble_dx(bubble_dx), .md_busy(md_busy), .md_done(md_done),
    .md_rd(md_rd)
`ifdef HAZ_STATS_EN
    ,
    .stat_fwd(stat_fwd), .stat_ldstall(stat_ldstall), .stat_mdstall(stat_mdstall)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  logic [15:0] expQ[$];
  string       tagQ[$];
  logic [15:0] obs;

  assign obs = {fwd_a, fwd_b, fwd_st, fd_byp1, fd_byp2, stall_fd, bubble_dx,
                md_busy, md_done, md_rd};

  // Expected output vector; bubble_dx always accompanies stall_fd
  function automatic logic [15:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic st, input logic b1, input logic b2,
                                     input logic stl, input logic busy, input logic done,
                                     input logic [AW-1:0] rd);
    return {fa, fb, st, b1, b2, stl, stl, busy, done, rd};
  endfunction

  task automatic clr();
    fd_rs1 = '0; fd_rs2 = '0; fd_rd = '0; fd_we = 1'b0; fd_is_md = 1'b0;
    dx_rs1 = '0; dx_rs2 = '0; dx_rd = '0; dx_we = 1'b0; dx_is_load = 1'b0; dx_is_md = 1'b0;
    xm_rd = '0; xm_we = 1'b0; xm_is_store = 1'b0; xm_rs2 = '0;
    mw_rd = '0; mw_we = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    clr();
  endtask

  task automatic chk(input string tag, input logic [15:0] e);
    logic [15:0] x;
    string       t;
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(negedge clock);
    x = expQ.pop_front();
    t = tagQ.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, obs, x);
    end
  endtask

  task automatic chkStat(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    clr();
    xm_we = 1'b1; xm_rd = 5'd3; dx_rs1 = 5'd3;
    chk("reset", 16'h0000);
    cyc(); reset = 1'b0;

    xm_we = 1'b1; xm_rd = 5'd3; mw_we = 1'b1; mw_rd = 5'd3; dx_rs1 = 5'd3;
    chk("xm_pri", ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));
    cyc(); xm_we = 1'b1; mw_we = 1'b1;
    chk("zero_reg", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));
    cyc(); xm_rd = 5'd9; mw_we = 1'b1; mw_rd = 5'd9; dx_rs1 = 5'd9; dx_rs2 = 5'd9;
    chk("mw_only", ev(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 5'd0));
    cyc(); xm_is_store = 1'b1; xm_rs2 = 5'd6; mw_we = 1'b1; mw_rd = 5'd6;
    fd_rs1 = 5'd6; fd_rs2 = 5'd6;
    chk("st_byp", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 5'd0));
    cyc(); xm_is_store = 1'b1; mw_we = 1'b1;
    chk("st_zero", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));

    cyc(); dx_is_load = 1'b1; dx_we = 1'b1; dx_rd = 5'd5; fd_rs2 = 5'd5;
    chk("ld_use", ev(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 5'd0));
    cyc(); xm_we = 1'b1; xm_rd = 5'd5; dx_rs2 = 5'd5; fd_rs2 = 5'd5;
    chk("ld_fwd", ev(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 5'd0));
    cyc(); dx_is_load = 1'b1; dx_we = 1'b1;
    chk("ld_rd0", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));
    cyc(); dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5;
    chk("ld_nowe", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));

    cyc(); dx_is_md = 1'b1; dx_rd = 5'd7;
    chk("md_start", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));
    cyc(); fd_rs1 = 5'd7;
    chk("md_raw", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 5'd7));
    cyc(); fd_rs1 = 5'd8; dx_is_md = 1'b1; dx_rd = 5'd3;
    chk("md_indep", ev(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 5'd7));
    cyc(); fd_is_md = 1'b1;
    chk("md_struct", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 5'd7));
    cyc(); fd_rs1 = 5'd7;
    chk("md_done", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 5'd7));
    cyc(); fd_rs1 = 5'd7;
    chk("md_release", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));

    cyc(); dx_is_md = 1'b1; dx_rd = 5'd7;
    chk("md2_start", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));
    cyc(); fd_we = 1'b1; fd_rd = 5'd7;
    chk("md2_waw", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 5'd7));
    cyc(); reset = 1'b1; fd_rs1 = 5'd7; xm_we = 1'b1; xm_rd = 5'd3; dx_rs1 = 5'd3;
    chk("rst_busy", 16'h0000);
    cyc(); reset = 1'b0; fd_rs1 = 5'd7;
    chk("post_rst", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));
    cyc();
    chk("no_done", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));

    cyc(); dx_is_md = 1'b1; dx_rd = 5'd12;
    chk("restart_go", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));
    for (int i = 1; i <= LAT; i++) begin
      cyc();
      chk($sformatf("restart_%0d", i), ev(2'b00, 2'b00, 0, 0, 0, 0, 1, (i == LAT), 5'd12));
    end
    cyc();
    chk("restart_idle", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0));

`ifdef HAZ_STATS_EN
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dx_is_load = 1'b1; dx_we = 1'b1; dx_rd = 5'd5; fd_rs2 = 5'd5;
      cyc();
    end
    for (int i = 0; i < 10; i++) begin
      xm_we = 1'b1; xm_rd = 5'd3; dx_rs1 = 5'd3;
      cyc();
    end
    @(negedge clock);
    chkStat("stat_ldstall", stat_ldstall, 16'd3);
    chkStat("stat_fwd", stat_fwd, 16'd10);
    chkStat("stat_mdstall", stat_mdstall, 16'd0);
    xm_we = 1'b1; xm_rd = 5'd3; dx_rs1 = 5'd3;
    repeat (65540) @(posedge clock);
    @(negedge clock);
    chkStat("stat_fwd_sat", stat_fwd, 16'hFFFF);
    clr();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
